// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the three bus sides of the memory arbiter.
//   cpu_* / dma_* : requester channels (req/wr/addr/wdata in, rdata/done/err out)
//   mem_*         : single shared memory port (req/wr/addr/wdata out, rdata/ack in)
//   owner         : current bus owner for trace (0 none, 1 CPU, 2 DMA)
// slave modport is the arbiter's view; master modport is the environment's view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_done;
  logic              cpu_err;

  logic              dma_req;
  logic              dma_wr;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_done;
  logic              dma_err;

  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic [1:0]        owner;

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done, cpu_err,
    input  dma_req, dma_wr, dma_addr, dma_wdata,
    output dma_rdata, dma_done, dma_err,
    output mem_req, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output owner
  );

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done, cpu_err,
    output dma_req, dma_wr, dma_addr, dma_wdata,
    input  dma_rdata, dma_done, dma_err,
    input  mem_req, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the CPU and a DMA master.
// CPU has fixed priority; DMA is forced to win after MAX_WAIT consecutive
// lost arbitrations. Each transaction aborts with err after TIMEOUT BUSY
// cycles without mem_ack.
// Ports:
//   clk  - clock, all state on posedge
//   rst  - asynchronous active-high reset
//   bus  - mem_arbiter_if.slave (cpu_*, dma_*, mem_*, owner)
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int TIMEOUT  = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int TO_W   = $clog2(TIMEOUT);

  // Encoding doubles as the owner trace value.
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BUSY_CPU = 2'd1;
  localparam logic [1:0] BUSY_DMA = 2'd2;

  logic [1:0]        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              busy, to_hit, fin, to_err, dma_wins;

  assign busy     = (state == BUSY_CPU) || (state == BUSY_DMA);
  assign to_hit   = (to_cnt == TO_W'(TIMEOUT - 1));
  // ack beats a coincident timeout
  assign fin      = busy && (bus.mem_ack || to_hit);
  assign to_err   = to_hit && !bus.mem_ack;
  assign dma_wins = bus.dma_req && (!bus.cpu_req || (wait_cnt >= WAIT_W'(MAX_WAIT)));

  always_comb begin
    bus.mem_req   = busy;
    bus.owner     = busy ? state : 2'd0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};
    bus.cpu_done  = 1'b0;
    bus.cpu_err   = 1'b0;
    bus.cpu_rdata = {DATA_W{1'b0}};
    bus.dma_done  = 1'b0;
    bus.dma_err   = 1'b0;
    bus.dma_rdata = {DATA_W{1'b0}};
    case (state)
      BUSY_CPU: begin
        bus.mem_wr    = bus.cpu_wr;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.cpu_done  = fin;
        bus.cpu_err   = to_err;
        bus.cpu_rdata = bus.mem_ack ? bus.mem_rdata : {DATA_W{1'b0}};
      end
      BUSY_DMA: begin
        bus.mem_wr    = bus.dma_wr;
        bus.mem_addr  = bus.dma_addr;
        bus.mem_wdata = bus.dma_wdata;
        bus.dma_done  = fin;
        bus.dma_err   = to_err;
        bus.dma_rdata = bus.mem_ack ? bus.mem_rdata : {DATA_W{1'b0}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (dma_wins) begin
            state    <= BUSY_DMA;
            wait_cnt <= '0;
          end else if (bus.cpu_req) begin
            state <= BUSY_CPU;
            // DMA lost this round: age it; no DMA pending clears the age
            if (!bus.dma_req)
              wait_cnt <= '0;
            else if (wait_cnt < WAIT_W'(MAX_WAIT))
              wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        BUSY_CPU, BUSY_DMA: begin
          if (fin) state <= IDLE;
          else     to_cnt <= to_cnt + TO_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios with literal expectations plus a
// randomized phase; a behavioural model (owner / age / busy-cycle count)
// is compared against every DUT output on every negedge outside reset.
module tb_mem_arbiter;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int TIMEOUT  = 4;
  localparam int MAX_WAIT = 2;

  logic clk, rst;
  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .MAX_WAIT(MAX_WAIT))
    dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  int m_owner;  // 0 none, 1 CPU, 2 DMA
  int m_age;    // lost arbitrations of a waiting DMA
  int m_busy;   // BUSY cycles already completed for current transaction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = 0; m_age = 0; m_busy = 0;
    end else if (m_owner == 0) begin
      m_busy = 0;
      if (bus.dma_req && (!bus.cpu_req || m_age >= MAX_WAIT)) begin
        m_owner = 2; m_age = 0;
      end else if (bus.cpu_req) begin
        m_owner = 1;
        m_age = bus.dma_req ? ((m_age + 1 > MAX_WAIT) ? MAX_WAIT : m_age + 1) : 0;
      end
    end else if (bus.mem_ack || m_busy == TIMEOUT - 1) begin
      m_owner = 0;
    end else begin
      m_busy = m_busy + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : cmp
    logic fin, to;
    logic [DATA_W-1:0] rd;
    if (!rst) begin
      fin = bus.mem_ack || (m_busy == TIMEOUT - 1);
      to  = !bus.mem_ack && (m_busy == TIMEOUT - 1);
      rd  = bus.mem_ack ? bus.mem_rdata : '0;
      chk("m_owner", bus.owner, m_owner);
      chk("m_mem_req", bus.mem_req, m_owner != 0);
      if (m_owner == 1) begin
        chk("m_mem_wr", bus.mem_wr, bus.cpu_wr);
        chk("m_mem_addr", bus.mem_addr, bus.cpu_addr);
        chk("m_mem_wdata", bus.mem_wdata, bus.cpu_wdata);
      end else if (m_owner == 2) begin
        chk("m_mem_wr", bus.mem_wr, bus.dma_wr);
        chk("m_mem_addr", bus.mem_addr, bus.dma_addr);
        chk("m_mem_wdata", bus.mem_wdata, bus.dma_wdata);
      end
      chk("m_cpu_done", bus.cpu_done, (m_owner == 1) && fin);
      chk("m_cpu_err", bus.cpu_err, (m_owner == 1) && to);
      chk("m_cpu_rdata", bus.cpu_rdata, (m_owner == 1) ? rd : '0);
      chk("m_dma_done", bus.dma_done, (m_owner == 2) && fin);
      chk("m_dma_err", bus.dma_err, (m_owner == 2) && to);
      chk("m_dma_rdata", bus.dma_rdata, (m_owner == 2) ? rd : '0);
    end
  end

  // ---------------- random requesters / memory ----------------
  bit rnd_en = 0;
  logic cpu_done_s, dma_done_s;
  always @(negedge clk) begin
    cpu_done_s = bus.cpu_done;
    dma_done_s = bus.dma_done;
  end

  always @(posedge clk) begin
    if (rnd_en) begin
      #1;
      bus.mem_ack   = ($urandom_range(0, 3) == 0);
      bus.mem_rdata = $urandom;
      if (!bus.cpu_req || cpu_done_s) begin
        if ($urandom_range(0, 2) == 0) bus.cpu_req = 1'b0;
        else begin
          bus.cpu_req = 1'b1; bus.cpu_wr = 1'($urandom);
          bus.cpu_addr = $urandom; bus.cpu_wdata = $urandom;
        end
      end
      if (!bus.dma_req || dma_done_s) begin
        if ($urandom_range(0, 2) == 0) bus.dma_req = 1'b0;
        else begin
          bus.dma_req = 1'b1; bus.dma_wr = 1'($urandom);
          bus.dma_addr = $urandom; bus.dma_wdata = $urandom;
        end
      end
    end
  end

  // ---------------- directed scenarios ----------------
  int exp_g[6] = '{1, 1, 2, 1, 1, 2};

  initial begin
    rst = 1'b1;
    bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 0; bus.dma_wr = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ack = 0;
    #2;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_owner", bus.owner, 0);
    chk("rst_cpu_done", bus.cpu_done, 0);
    chk("rst_dma_done", bus.dma_done, 0);
    chk("rst_cpu_err", bus.cpu_err, 0);
    chk("rst_dma_err", bus.dma_err, 0);
    #11 rst = 1'b0;

    // CPU read alone, ack on 3rd BUSY cycle
    step(); bus.cpu_req = 1; bus.cpu_wr = 0; bus.cpu_addr = 32'h0000_0010;
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 3) begin bus.mem_ack = 1; bus.mem_rdata = 32'hDEAD_BEEF; end
      @(negedge clk);
      chk("rd_mem_req", bus.mem_req, 1);
      chk("rd_owner", bus.owner, 1);
      chk("rd_cpu_done", bus.cpu_done, c == 3);
      chk("rd_dma_done", bus.dma_done, 0);
      if (c == 3) begin
        chk("rd_cpu_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
        chk("rd_cpu_err", bus.cpu_err, 0);
        chk("rd_dma_rdata", bus.dma_rdata, 0);
      end
    end
    step(); bus.mem_ack = 0; bus.cpu_req = 0;
    @(negedge clk);
    chk("rd_idle_after", bus.mem_req, 0);

    // Simultaneous requests, MAX_WAIT=2, 1-cycle ack
    step(); bus.cpu_req = 1; bus.dma_req = 1; bus.dma_addr = 32'h100; bus.cpu_addr = 32'h200;
    for (int k = 0; k < 6; k++) begin
      step(); bus.mem_ack = 1; bus.mem_rdata = $urandom;
      @(negedge clk);
      chk("grant_order", bus.owner, exp_g[k]);
      if (exp_g[k] == 1) chk("grant_cpu_done", bus.cpu_done, 1);
      else begin
        chk("grant_dma_done", bus.dma_done, 1);
        chk("wait_cnt_clr", dut.wait_cnt, 0);
      end
      step(); bus.mem_ack = 0;
      if (exp_g[k] == 1) bus.cpu_addr = $urandom; else bus.dma_addr = $urandom;
      @(negedge clk);
      chk("gap_idle", bus.mem_req, 0);
    end
    bus.cpu_req = 0; bus.dma_req = 0;
    step();

    // DMA write timeout, TIMEOUT=4
    step(); bus.dma_req = 1; bus.dma_wr = 1; bus.dma_addr = 32'h40; bus.dma_wdata = 32'h5555_AAAA;
    for (int c = 1; c <= 4; c++) begin
      step();
      @(negedge clk);
      chk("to_mem_req", bus.mem_req, 1);
      chk("to_dma_done", bus.dma_done, c == 4);
      chk("to_dma_err", bus.dma_err, c == 4);
      if (c == 4) chk("to_dma_rdata", bus.dma_rdata, 0);
    end
    step(); bus.dma_req = 0; bus.mem_ack = 1; bus.mem_rdata = 32'h1111_2222;
    @(negedge clk);
    chk("to_after_req", bus.mem_req, 0);
    chk("to_late_ack_done", bus.dma_done, 0);
    chk("to_late_ack_err", bus.dma_err, 0);
    step(); bus.mem_ack = 0;
    @(negedge clk);
    chk("to_idle", bus.owner, 0);

    // Ack on the timeout cycle
    step(); bus.cpu_req = 1; bus.cpu_wr = 0; bus.cpu_addr = 32'h30;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 4) begin bus.mem_ack = 1; bus.mem_rdata = 32'hCAFE_F00D; end
      @(negedge clk);
      chk("ackto_done", bus.cpu_done, c == 4);
      chk("ackto_err", bus.cpu_err, 0);
      if (c == 4) chk("ackto_rdata", bus.cpu_rdata, 32'hCAFE_F00D);
    end
    step(); bus.mem_ack = 0; bus.cpu_req = 0;
    @(negedge clk);
    chk("ackto_idle", bus.owner, 0);

    // Async reset mid-transaction
    step(); bus.cpu_req = 1; bus.cpu_addr = 32'h50;
    step(); bus.mem_ack = 1; bus.mem_rdata = 32'h7;
    #1;
    chk("arst_pre_done", bus.cpu_done, 1);
    rst = 1;
    #1;
    chk("arst_mem_req", bus.mem_req, 0);
    chk("arst_owner", bus.owner, 0);
    chk("arst_cpu_done", bus.cpu_done, 0);
    bus.mem_ack = 0; rst = 0;
    step();
    @(negedge clk);
    chk("arst_regrant_owner", bus.owner, 1);
    chk("arst_regrant_req", bus.mem_req, 1);
    step(); bus.mem_ack = 1;
    @(negedge clk);
    chk("arst_fin_done", bus.cpu_done, 1);
    step(); bus.mem_ack = 0; bus.cpu_req = 0;

    // Write passthrough
    step(); bus.cpu_req = 1; bus.cpu_wr = 1; bus.cpu_addr = 32'h20;
    bus.cpu_wdata = 32'h1234_5678; bus.mem_rdata = '0;
    for (int c = 1; c <= 2; c++) begin
      step();
      if (c == 2) bus.mem_ack = 1;
      @(negedge clk);
      chk("wr_mem_wr", bus.mem_wr, 1);
      chk("wr_mem_addr", bus.mem_addr, 32'h20);
      chk("wr_mem_wdata", bus.mem_wdata, 32'h1234_5678);
      chk("wr_cpu_done", bus.cpu_done, c == 2);
      if (c == 2) chk("wr_cpu_rdata", bus.cpu_rdata, 0);
    end
    step(); bus.mem_ack = 0; bus.cpu_req = 0; bus.cpu_wr = 0;

    // Randomized phase with occasional async reset pulses
    rnd_en = 1;
    for (int r = 0; r < 6; r++) begin
      repeat (500) @(posedge clk);
      #3 rst = 1;
      #1 rst = 0;
    end
    repeat (200) @(posedge clk);
    rnd_en = 0;
    step(); bus.cpu_req = 0; bus.dma_req = 0; bus.mem_ack = 0;
    repeat (TIMEOUT + 2) step();
    @(negedge clk);
    chk("end_idle", bus.mem_req, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
